// File: rtl/stopwatch_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_pkg : shared types and field offsets for the BCD stopwatch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  localparam int CS_LSB  = 0;
  localparam int SEC_LSB = 8;
  localparam int MIN_LSB = 16;
  localparam int HR_LSB  = 24;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t hr_t;
    bcd_digit_t hr_u;
    bcd_digit_t min_t;
    bcd_digit_t min_u;
    bcd_digit_t sec_t;
    bcd_digit_t sec_u;
    bcd_digit_t cs_t;
    bcd_digit_t cs_u;
  } sw_time_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ----------------------------------------------------------------------------
// bcd_digit_counter : one BCD digit that wraps at MAX and emits a carry
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output bcd_digit_t digit,
  output logic       carry
);

  localparam bcd_digit_t LIMIT = bcd_digit_t'(MAX);

  bcd_digit_t value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= (value == LIMIT) ? '0 : value + 4'd1;
    end
  end

  assign digit = value;
  assign carry = en && (value == LIMIT);

endmodule

`default_nettype wire

// File: rtl/stopwatch_core.sv
// ----------------------------------------------------------------------------
// stopwatch_core : command FSM, tick prescaler, BCD time chain and lap capture
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  input  logic        cmd_lap,
  output logic [31:0] time_out,
  output logic [31:0] lap_out,
  output logic        lap_valid,
  output logic        running,
  output logic        overflow
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  if ((DIV < 2) || (DIV * TICK_HZ != CLK_FREQ_HZ)) begin : g_bad_div
    $error("stopwatch_core: CLK_FREQ_HZ/TICK_HZ must be an exact integer >= 2");
  end

  sw_state_t     state;
  sw_state_t     state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  sw_time_t      lap_r;

  // Higher-priority commands mask lower ones even where they are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!cmd_clear && !cmd_stop && cmd_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cmd_clear)     state_nxt = ST_IDLE;
        else if (cmd_stop) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (cmd_clear)                   state_nxt = ST_IDLE;
        else if (!cmd_stop && cmd_start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
    end
  end

  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

  // Prescaler holds in PAUSE so a resume keeps the partial centisecond.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      presc <= '0;
    end else if (cmd_clear) begin
      presc <= '0;
    end else begin
      case (state)
        ST_RUN:   presc <= tick ? '0 : presc + 1'b1;
        ST_PAUSE: presc <= presc;
        default:  presc <= '0;
      endcase
    end
  end

  bcd_digit_t cs_u, cs_t, sec_u, sec_t, min_u, min_t, hr_u, hr_t;
  logic carry_cs_u, carry_cs_t, carry_sec_u, carry_sec_t;
  logic carry_min_u, carry_min_t, carry_hr_u, carry_hr_t;

  bcd_digit_counter #(.MAX(9)) u_cs_u (
    .clk(ACLK), .rst(ARESET), .en(tick), .clr(cmd_clear), .digit(cs_u), .carry(carry_cs_u));
  bcd_digit_counter #(.MAX(9)) u_cs_t (
    .clk(ACLK), .rst(ARESET), .en(carry_cs_u), .clr(cmd_clear), .digit(cs_t), .carry(carry_cs_t));
  bcd_digit_counter #(.MAX(9)) u_sec_u (
    .clk(ACLK), .rst(ARESET), .en(carry_cs_t), .clr(cmd_clear), .digit(sec_u), .carry(carry_sec_u));
  bcd_digit_counter #(.MAX(5)) u_sec_t (
    .clk(ACLK), .rst(ARESET), .en(carry_sec_u), .clr(cmd_clear), .digit(sec_t), .carry(carry_sec_t));
  bcd_digit_counter #(.MAX(9)) u_min_u (
    .clk(ACLK), .rst(ARESET), .en(carry_sec_t), .clr(cmd_clear), .digit(min_u), .carry(carry_min_u));
  bcd_digit_counter #(.MAX(5)) u_min_t (
    .clk(ACLK), .rst(ARESET), .en(carry_min_u), .clr(cmd_clear), .digit(min_t), .carry(carry_min_t));
  bcd_digit_counter #(.MAX(9)) u_hr_u (
    .clk(ACLK), .rst(ARESET), .en(carry_min_t), .clr(cmd_clear), .digit(hr_u), .carry(carry_hr_u));
  bcd_digit_counter #(.MAX(9)) u_hr_t (
    .clk(ACLK), .rst(ARESET), .en(carry_hr_u), .clr(cmd_clear), .digit(hr_t), .carry(carry_hr_t));

  assign time_out[CS_LSB  +: 8] = {cs_t, cs_u};
  assign time_out[SEC_LSB +: 8] = {sec_t, sec_u};
  assign time_out[MIN_LSB +: 8] = {min_t, min_u};
  assign time_out[HR_LSB  +: 8] = {hr_t, hr_u};

  // Carry out of the hours tens digit means the whole chain just wrapped.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      overflow <= 1'b0;
    end else if (cmd_clear) begin
      overflow <= 1'b0;
    end else if (carry_hr_t) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      lap_r     <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= cmd_lap;
      if (cmd_lap) lap_r <= sw_time_t'(time_out);
    end
  end

  assign lap_out = lap_r;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_core.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_core : scoreboard bench with a centisecond-count reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_core;

  localparam int DIV     = 10;
  localparam int WRAP_CS = 100 * 360000;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_start, cmd_stop, cmd_clear, cmd_lap;
  logic [31:0] time_out, lap_out;
  logic        lap_valid, running, overflow;

  stopwatch_core #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .cmd_lap(cmd_lap),
    .time_out(time_out), .lap_out(lap_out), .lap_valid(lap_valid),
    .running(running), .overflow(overflow));

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] t;
    logic [31:0] lap;
    logic        lv;
    logic        run;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] lap_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: elapsed time as a plain centisecond count.
  int          m_state;   // 0 idle, 1 run, 2 pause
  int          m_phase;
  int          m_cs;
  bit          m_ovf;
  bit          m_lv;
  logic [31:0] m_lap;

  function automatic logic [31:0] to_bcd(int t);
    int h, m, s, c;
    h = t / 360000;
    m = (t / 6000) % 60;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_cs = 0; m_ovf = 0; m_lv = 0; m_lap = '0;
    lap_q.delete();
  endtask

  task automatic push_exp();
    exp_t e;
    e.t = to_bcd(m_cs); e.lap = m_lap; e.lv = m_lv;
    e.run = (m_state == 1); e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic cycle(bit rst, bit st, bit sp, bit cl, bit lp);
    bit tick;
    @(negedge ACLK);
    ARESET = rst; cmd_start = st; cmd_stop = sp; cmd_clear = cl; cmd_lap = lp;
    if (rst) begin
      model_reset();
    end else begin
      m_lv = lp;
      if (lp) begin
        m_lap = to_bcd(m_cs);
        lap_q.push_back(m_lap);
      end
      tick = (m_state == 1) && (m_phase == DIV - 1);
      if (cl) begin
        m_cs = 0; m_phase = 0; m_ovf = 0; m_state = 0;
      end else begin
        if (tick) begin
          m_cs++;
          if (m_cs == WRAP_CS) begin m_cs = 0; m_ovf = 1; end
        end
        if (m_state == 1) m_phase = (m_phase + 1) % DIV;
        if (sp) begin
          if (m_state == 1) m_state = 2;
        end else if (st) begin
          if (m_state != 1) m_state = 1;
        end
      end
    end
    push_exp();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Backdoor the paused DUT to 99:59:59.99 so the wrap is reachable quickly.
  task automatic preload_max();
    @(negedge ACLK);
    cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_lap = 0;
    force dut.u_cs_u.value  = 4'h9;
    force dut.u_cs_t.value  = 4'h9;
    force dut.u_sec_u.value = 4'h9;
    force dut.u_sec_t.value = 4'h5;
    force dut.u_min_u.value = 4'h9;
    force dut.u_min_t.value = 4'h5;
    force dut.u_hr_u.value  = 4'h9;
    force dut.u_hr_t.value  = 4'h9;
    m_cs = WRAP_CS - 1;
    m_lv = 0;
    push_exp();
    @(posedge ACLK);
    #2;
    release dut.u_cs_u.value;
    release dut.u_cs_t.value;
    release dut.u_sec_u.value;
    release dut.u_sec_t.value;
    release dut.u_min_u.value;
    release dut.u_min_t.value;
    release dut.u_hr_u.value;
    release dut.u_hr_t.value;
  endtask

  exp_t mon_e;

  always @(posedge ACLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("time_out", time_out, mon_e.t);
      chk("lap_out", lap_out, mon_e.lap);
      chk("lap_valid", {31'd0, lap_valid}, {31'd0, mon_e.lv});
      chk("running", {31'd0, running}, {31'd0, mon_e.run});
      chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
    end
    if (lap_valid === 1'b1) begin
      if (lap_q.size() == 0) chk("lap_unexpected", 32'd1, 32'd0);
      else                   chk("lap_capture", lap_out, lap_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1; cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_lap = 0;
    model_reset();
    #3;
    chk("reset_time", time_out, 32'd0);
    chk("reset_lap", lap_out, 32'd0);
    chk("reset_flags", {29'd0, lap_valid, running, overflow}, 32'd0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(5);

    // Run from reset for 1000 cycles, then pause and resume mid-phase.
    cycle(0, 1, 0, 0, 0);
    idle(1000);
    cycle(0, 0, 1, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    idle(24);
    cycle(0, 0, 1, 0, 0);
    idle(50);
    cycle(0, 1, 0, 0, 0);
    idle(20);

    // Lap exactly at 03.17 s, then back-to-back laps.
    for (int g = 0; g < 4000 && to_bcd(m_cs) != 32'h0000_0317; g++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    idle(15);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    idle(5);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Wrap past 99:59:59.99.
    preload_max();
    cycle(0, 1, 0, 0, 0);
    idle(25);
    cycle(0, 0, 0, 1, 1);
    idle(3);
    cycle(0, 1, 0, 0, 0);
    idle(33);
    cycle(0, 1, 1, 1, 0);
    idle(4);

    // Asynchronous reset in the middle of a run.
    cycle(0, 1, 0, 0, 0);
    idle(37);
    @(posedge ACLK);
    #3;
    ARESET = 1;
    #1;
    chk("async_rst_time", time_out, 32'd0);
    chk("async_rst_lap", lap_out, 32'd0);
    chk("async_rst_flags", {29'd0, lap_valid, running, overflow}, 32'd0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(30);

    // Randomised command traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(0, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12);
    end
    idle(2);

    @(posedge ACLK);
    #2;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("lap_q_drained", lap_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_core.md
# stopwatch_core

Time-keeping datapath directly downstream of the `stopwatch_controller` AXI4-Lite register slave. It consumes that slave's start, stop, clear and lap command pulses and runs a BCD stopwatch with a 10 ms resolution. It returns the running time, a captured lap time and status flags to the slave's read-back registers.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000: `ACLK` frequency.
- `TICK_HZ`, default 100: centisecond tick rate.
- `DIV = CLK_FREQ_HZ/TICK_HZ` is derived, not overridable. Elaboration error if `DIV < 2` or the division is not exact.

Ports (clock and reset first):
- `ACLK` in 1: single clock for the whole block.
- `ARESET` in 1: reset, asynchronous and active-high.
- `cmd_start` in 1: one-cycle pulse, start or resume.
- `cmd_stop` in 1: one-cycle pulse, pause.
- `cmd_clear` in 1: one-cycle pulse, zero the time and return to idle.
- `cmd_lap` in 1: one-cycle pulse, capture the current time.
- `time_out` out 32: packed BCD running time.
  - [31:24] hours 00-99
  - [23:16] minutes 00-59
  - [15:8] seconds 00-59
  - [7:0] centiseconds 00-99
- `lap_out` out 32: last captured time, same packing as `time_out`.
- `lap_valid` out 1: one-cycle pulse when `lap_out` updates.
- `running` out 1: high in RUN.
- `overflow` out 1: sticky; set on wrap past 99:59:59.99.

## Operation
- State machine states: IDLE, RUN, PAUSE.
  - IDLE: `cmd_start` goes to RUN.
  - RUN: `cmd_stop` goes to PAUSE; `cmd_clear` goes to IDLE.
  - PAUSE: `cmd_start` goes to RUN; `cmd_clear` goes to IDLE.
  - Commands not listed for a state are ignored.
- Command priority within one cycle: clear > stop > start. `cmd_lap` is independent of the other commands.
- Prescaler `presc`, `$clog2(DIV)` bits:
  - Increments only in RUN.
  - At `presc == DIV-1`: wraps to 0 and asserts an internal `tick` for one cycle.
  - Holds its value in PAUSE, so pause and resume preserve the sub-tick phase.
  - Zeroed in IDLE and on clear.
- BCD counter chain, advanced by `tick`:
  - Each BCD digit wraps at its own maximum, 9 or 5 as the field's range requires.
  - A digit's carry enables the next digit.
  - Carry order: centiseconds → seconds → minutes → hours.
- Wrap at 99:59:59.99:
  - `time_out` wraps to 0 and `overflow` sets.
  - `overflow` clears only on `cmd_clear` or `ARESET`.
- `cmd_clear`: zeroes `time_out`, `presc` and `overflow`. It does not alter `lap_out`.
- `cmd_lap`:
  - Accepted in any state, including IDLE.
  - Captures the `time_out` value present in the cycle `cmd_lap` is high, before any same-cycle tick update.
- Lap and clear in the same cycle: the lap captures the pre-clear time.
- Reset mid-operation: all registers return immediately to their reset values, regardless of state.

## Timing
- Reset values:
  - `time_out` = 0
  - `lap_out` = 0
  - `lap_valid` = 0
  - `running` = 0
  - `overflow` = 0
  - state = IDLE
  - `presc` = 0
- All outputs are registered. There are no combinational input-to-output paths.
- `cmd_start` high at edge N: `running` = 1 after edge N+1.
  - From IDLE: first centisecond increment visible after edge N+DIV+1.
  - From PAUSE: first increment arrives `DIV - presc` cycles after RUN entry (remaining sub-tick phase).
- `cmd_stop` at edge N: `running` = 0 after edge N+1. A tick that is due in that same cycle is still applied.
- `cmd_lap` at edge N: `lap_out` updates and `lap_valid` pulses, both after edge N+1. `lap_valid` is high for exactly one cycle.
- Back-to-back `cmd_lap` on consecutive cycles: each pulse yields its own `lap_valid` pulse and `lap_out` update.
- Carry ripple settles within the tick cycle. `time_out` updates in a single cycle, with no intermediate values visible.

## Structure
- Package `stopwatch_pkg` holds:
  - `sw_state_t` enum (IDLE, RUN, PAUSE).
  - Field LSB offsets: 0, 8, 16, 24.
  - `bcd_digit_t` (4-bit).
  - A 32-bit `sw_time_t` packed struct.
- Sub-module `bcd_digit_counter`:
  - Parameter `MAX`.
  - Inputs `en`, `clr`; outputs `digit`, `carry`.
  - Instantiated 8 times; hours have no upper limit beyond 99.
- Top level holds the FSM, prescaler, lap register and overflow flag.

## Test plan
All scenarios use `CLK_FREQ_HZ=1000`, `TICK_HZ=100`, giving DIV=10.
- Start after reset, run 1000 cycles → `time_out` = 0x0000_0100 (01.00 s), `running` = 1.
- Start, stop after 25 cycles, idle 50 cycles, restart → `time_out` at stop = 0x02, unchanged during pause; next increment exactly 5 cycles after RUN entry.
- `cmd_lap` at 0x0000_0317, then continue running → `lap_out` = 0x0000_0317 one cycle later, `lap_valid` high one cycle, `time_out` keeps advancing.
- Preload-equivalent run to 0x9959_5999 (force via long sim or backdoor), one more tick → `time_out` = 0, `overflow` = 1; then `cmd_clear` → `overflow` = 0, state IDLE.
- Simultaneous start+stop+clear in RUN → IDLE, `time_out` = 0; simultaneous lap+clear → `lap_out` = pre-clear time.
- Assert `ARESET` mid-RUN asynchronously (not clock-aligned) → all outputs 0 immediately; no tick after release until `cmd_start`.
